// File: rtl/mbs_bus_pkg.sv
// Shared definitions for the MBSsoc interconnect: default address map and
// the bit layout of the per-grant control bus used inside the arbiter.
package mbs_bus_pkg;

  // Default address map (32-bit system addresses)
  localparam logic [31:0] MBS_RAM_LIMIT      = 32'h0200_0000;
  localparam logic [31:0] MBS_APIC_CONF_ADDR = 32'hFFFF_0000;
  localparam logic [31:0] MBS_APIC_PC_BASE   = 32'hFFFF_0010;
  localparam logic [31:0] MBS_UART_DATA_ADDR = 32'hFFFF_0100;

  // Control-bus bit indices for the granted access
  localparam int unsigned CTRL_RE   = 0;
  localparam int unsigned CTRL_WE   = 1;
  localparam int unsigned CTRL_LOCK = 2;
  localparam int unsigned CTRL_W    = 3;

  // Stride between consecutive per-core APIC PC registers
  localparam int unsigned APIC_PC_STRIDE = 4;

endpackage

// File: rtl/mbs_rr_picker.sv
// Combinational round-robin picker: returns the first set request at or
// after the pointer, searching upward with wrap-around. When nothing is
// requested the index is 0 and the one-hot grant is all zeros.
module mbs_rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_oh_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          grant_any_o
);

  // Scan N candidates starting at the pointer; first hit wins
  always_comb begin
    int unsigned cand;
    logic        found;
    cand        = 0;
    found       = 1'b0;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // pointer is always < N, so one subtraction handles the wrap
      cand = int'(ptr_i) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req_i[cand]) begin
        found             = 1'b1;
        grant_oh_o[cand]  = 1'b1;
        grant_idx_o       = IW'(cand);
      end
    end
    grant_any_o = found;
  end

endmodule

// File: rtl/mbs_bus_arbiter_rr.sv
// N-core shared-bus arbiter with address decode and per-core LL/SC
// reservation table. Arbitration and decode are combinational; only the
// round-robin pointer, the reservations and the SC-fail pulse are registered.
module mbs_bus_arbiter_rr
  import mbs_bus_pkg::*;
#(
  parameter int unsigned CORE_NUM   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RAM_LIMIT      = ADDR_WIDTH'(MBS_RAM_LIMIT),
  parameter logic [ADDR_WIDTH-1:0] APIC_CONF_ADDR = ADDR_WIDTH'(MBS_APIC_CONF_ADDR),
  parameter logic [ADDR_WIDTH-1:0] APIC_PC_BASE   = ADDR_WIDTH'(MBS_APIC_PC_BASE),
  parameter logic [ADDR_WIDTH-1:0] UART_DATA_ADDR = ADDR_WIDTH'(MBS_UART_DATA_ADDR),
  parameter int unsigned IW = $clog2(CORE_NUM)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CORE_NUM-1:0]            req_re,
  input  logic [CORE_NUM-1:0]            req_we,
  input  logic [CORE_NUM-1:0]            req_lock,
  input  logic [CORE_NUM*ADDR_WIDTH-1:0] req_addr,
  output logic [CORE_NUM-1:0]            cpu_pause,
  output logic                           grant_valid,
  output logic [IW-1:0]                  grant_sel,
  output logic                           ram_re,
  output logic                           ram_we,
  output logic [ADDR_WIDTH-1:0]          ram_addr,
  output logic                           ram_wr_invalid,
  output logic                           apic_conf,
  output logic [CORE_NUM-1:0]            apic_pc,
  output logic                           uart_we,
  output logic [CORE_NUM-1:0]            sc_fail
);

  // Handshake: there is no ready/valid pair here. A core holds req_re or
  // req_we (plus req_lock for LL/SC) until it is granted; cpu_pause high means
  // "not this cycle, hold your request". An access completes in the cycle
  // its core is granted and not paused.

  logic [CORE_NUM-1:0]   req;
  logic [CORE_NUM-1:0]   grant_oh;
  logic [ADDR_WIDTH-1:0] addr_arr [CORE_NUM];
  logic [ADDR_WIDTH-1:0] addr;
  logic [CTRL_W-1:0]     ctrl;
  logic                  in_ram;
  logic                  sc_ok;
  logic                  sc_bad;
  logic                  write_ok;

  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CORE_NUM-1:0]   resv_v_q, resv_v_d;
  logic [ADDR_WIDTH-1:0] resv_a_q [CORE_NUM];
  logic [ADDR_WIDTH-1:0] resv_a_d [CORE_NUM];
  logic [CORE_NUM-1:0]   sc_fail_q, sc_fail_d;

  // A core requests on read or write
  assign req = req_re | req_we;

  for (genvar i = 0; i < CORE_NUM; i++) begin : g_addr
    assign addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  mbs_rr_picker #(
    .N  (CORE_NUM),
    .IW (IW)
  ) u_picker (
    .req_i       (req),
    .ptr_i       (rr_ptr_q),
    .grant_oh_o  (grant_oh),
    .grant_idx_o (grant_sel),
    .grant_any_o (grant_valid)
  );

  assign cpu_pause = req & ~grant_oh;

  // Build the granted core's control bus and classify its access
  always_comb begin
    ctrl = '0;
    addr = '0;
    if (grant_valid) begin
      addr            = addr_arr[grant_sel];
      // write wins when a core raises re and we together
      ctrl[CTRL_WE]   = req_we[grant_sel];
      ctrl[CTRL_RE]   = req_re[grant_sel] & ~req_we[grant_sel];
      ctrl[CTRL_LOCK] = req_lock[grant_sel];
    end
    in_ram   = (addr < RAM_LIMIT);
    // reservations only exist for RAM, so an SC to I/O space always fails
    sc_ok    = ctrl[CTRL_WE] & ctrl[CTRL_LOCK] & in_ram &
               resv_v_q[grant_sel] & (resv_a_q[grant_sel] == addr);
    sc_bad   = ctrl[CTRL_WE] & ctrl[CTRL_LOCK] & ~sc_ok;
    write_ok = ctrl[CTRL_WE] & ~sc_bad;
  end

  // Address decode into RAM / APIC / UART strobes
  always_comb begin
    // the granted address is passed through; only strobes qualify it
    ram_addr       = addr;
    ram_re         = ctrl[CTRL_RE] & in_ram;
    ram_we         = write_ok & in_ram;
    ram_wr_invalid = sc_bad;
    apic_conf      = write_ok & ~in_ram & (addr == APIC_CONF_ADDR);
    uart_we        = write_ok & ~in_ram & (addr == UART_DATA_ADDR);
    apic_pc        = '0;
    for (int unsigned i = 0; i < CORE_NUM; i++) begin
      apic_pc[i] = write_ok & ~in_ram &
                   (addr == APIC_PC_BASE + ADDR_WIDTH'(APIC_PC_STRIDE * i));
    end
  end

  // Next-state for pointer, reservation table and SC-fail pulse
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    resv_v_d  = resv_v_q;
    resv_a_d  = resv_a_q;
    sc_fail_d = '0;
    if (grant_valid) begin
      rr_ptr_d = (grant_sel == IW'(CORE_NUM - 1)) ? '0 : grant_sel + 1'b1;
    end
    // a completed write kills other cores' reservations on that address
    for (int unsigned k = 0; k < CORE_NUM; k++) begin
      if (write_ok && (IW'(k) != grant_sel) && (resv_a_q[k] == addr)) begin
        resv_v_d[k] = 1'b0;
      end
    end
    if (ctrl[CTRL_RE] && ctrl[CTRL_LOCK] && in_ram) begin
      resv_v_d[grant_sel] = 1'b1;
      resv_a_d[grant_sel] = addr;
    end
    if (sc_ok)  resv_v_d[grant_sel]  = 1'b0;
    if (sc_bad) sc_fail_d[grant_sel] = 1'b1;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      resv_v_q  <= '0;
      sc_fail_q <= '0;
      for (int unsigned k = 0; k < CORE_NUM; k++) resv_a_q[k] <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      resv_v_q  <= resv_v_d;
      sc_fail_q <= sc_fail_d;
      for (int unsigned k = 0; k < CORE_NUM; k++) resv_a_q[k] <= resv_a_d[k];
    end
  end

  assign sc_fail = sc_fail_q;

endmodule

// File: tb/tb_mbs_bus_arbiter_rr.sv
// Directed bench for mbs_bus_arbiter_rr (4 cores, 32-bit addresses).
// The driver applies one vector per cycle and queues its hand-computed
// expected output word; the monitor pops and compares on the falling edge.
module tb_mbs_bus_arbiter_rr;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned EW = 52;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req_re, req_we, req_lock;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    cpu_pause, apic_pc, sc_fail;
  logic            grant_valid, ram_re, ram_we, ram_wr_invalid, apic_conf, uart_we;
  logic [1:0]      grant_sel;
  logic [AW-1:0]   ram_addr;

  mbs_bus_arbiter_rr #(.CORE_NUM(N), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_re         (req_re),
    .req_we         (req_we),
    .req_lock       (req_lock),
    .req_addr       (req_addr),
    .cpu_pause      (cpu_pause),
    .grant_valid    (grant_valid),
    .grant_sel      (grant_sel),
    .ram_re         (ram_re),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_wr_invalid (ram_wr_invalid),
    .apic_conf      (apic_conf),
    .apic_pc        (apic_pc),
    .uart_we        (uart_we),
    .sc_fail        (sc_fail)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            total = 0;
  int            bad   = 0;

  // {gv, gsel, pause, ram_re, ram_we, ram_addr, wr_inv, apic_conf, apic_pc, uart_we, sc_fail}
  function automatic logic [EW-1:0] pk(input logic gv, input logic [1:0] gs,
      input logic [3:0] pa, input logic rr, input logic rw, input logic [31:0] ra,
      input logic inv, input logic cf, input logic [3:0] pc, input logic uw,
      input logic [3:0] sf);
    return {gv, gs, pa, rr, rw, ra, inv, cf, pc, uw, sf};
  endfunction

  // monitor: one expected word per driven cycle
  initial begin
    logic [EW-1:0] e, a;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = pk(grant_valid, grant_sel, cpu_pause, ram_re, ram_we, ram_addr,
                ram_wr_invalid, apic_conf, apic_pc, uart_we, sc_fail);
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL %s: got %h expected %h", nm, a, e);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input string nm, input logic rst, input logic [3:0] re,
      input logic [3:0] we, input logic [3:0] lk, input logic [31:0] a0,
      input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] a3,
      input logic [EW-1:0] e);
    @(posedge clk);
    #1;
    rst_n    = rst;
    req_re   = re;
    req_we   = we;
    req_lock = lk;
    req_addr = {a3, a2, a1, a0};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle(input string nm, input logic [3:0] sf);
    step(nm, 1'b1, 4'h0, 4'h0, 4'h0, '0, '0, '0, '0,
         pk(0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, sf));
  endtask

  localparam logic [31:0] A0 = 32'h100, A1 = 32'h110, A2 = 32'h120, A3 = 32'h130;
  localparam logic [31:0] Z  = 32'h0;

  initial begin
    rst_n = 1'b0; req_re = '0; req_we = '0; req_lock = '0; req_addr = '0;
    repeat (3) @(posedge clk);

    step("rst_hold", 0, 4'h0, 4'h0, 4'h0, Z, Z, Z, Z, pk(0,0,0,0,0,Z,0,0,0,0,0));

    // round-robin: all cores read RAM
    step("rr0", 1, 4'hF, 4'h0, 4'h0, A0, A1, A2, A3, pk(1,0,4'b1110,1,0,A0,0,0,0,0,0));
    step("rr1", 1, 4'hF, 4'h0, 4'h0, A0, A1, A2, A3, pk(1,1,4'b1101,1,0,A1,0,0,0,0,0));
    step("rr2", 1, 4'hF, 4'h0, 4'h0, A0, A1, A2, A3, pk(1,2,4'b1011,1,0,A2,0,0,0,0,0));
    step("rr3", 1, 4'hF, 4'h0, 4'h0, A0, A1, A2, A3, pk(1,3,4'b0111,1,0,A3,0,0,0,0,0));
    step("rr4", 1, 4'hF, 4'h0, 4'h0, A0, A1, A2, A3, pk(1,0,4'b1110,1,0,A0,0,0,0,0,0));

    // decode
    step("dec_apic_pc", 1, 4'h0, 4'b0100, 4'h0, Z, Z, 32'hFFFF_0018, Z,
         pk(1,2,0,0,0,32'hFFFF_0018,0,0,4'b0100,0,0));
    step("dec_ram_rd", 1, 4'b0010, 4'h0, 4'h0, Z, 32'h1000, Z, Z,
         pk(1,1,0,1,0,32'h1000,0,0,0,0,0));
    step("dec_apic_conf", 1, 4'h0, 4'b0001, 4'h0, 32'hFFFF_0000, Z, Z, Z,
         pk(1,0,0,0,0,32'hFFFF_0000,0,1,0,0,0));
    step("dec_uart", 1, 4'h0, 4'b1000, 4'h0, Z, Z, Z, 32'hFFFF_0100,
         pk(1,3,0,0,0,32'hFFFF_0100,0,0,0,1,0));
    step("dec_io_rd", 1, 4'b0001, 4'h0, 4'h0, 32'hFFFF_0100, Z, Z, Z,
         pk(1,0,0,0,0,32'hFFFF_0100,0,0,0,0,0));
    step("dec_unmapped", 1, 4'h0, 4'b0010, 4'h0, Z, 32'h8000_0000, Z, Z,
         pk(1,1,0,0,0,32'h8000_0000,0,0,0,0,0));
    idle("idle", 4'h0);

    // LL/SC success, then a repeated SC with the reservation consumed
    step("ll_c1", 1, 4'b0010, 4'h0, 4'b0010, Z, 32'h40, Z, Z, pk(1,1,0,1,0,32'h40,0,0,0,0,0));
    step("sc_c1_ok", 1, 4'h0, 4'b0010, 4'b0010, Z, 32'h40, Z, Z, pk(1,1,0,0,1,32'h40,0,0,0,0,0));
    idle("sc_ok_nofail", 4'h0);
    step("sc_c1_again", 1, 4'h0, 4'b0010, 4'b0010, Z, 32'h40, Z, Z, pk(1,1,0,0,0,32'h40,1,0,0,0,0));
    idle("sc_fail_c1", 4'b0010);

    // reservation stolen by another core's plain write
    step("ll_c0", 1, 4'b0001, 4'h0, 4'b0001, 32'h80, Z, Z, Z, pk(1,0,0,1,0,32'h80,0,0,0,0,0));
    step("steal_wr_c3", 1, 4'h0, 4'b1000, 4'h0, Z, Z, Z, 32'h80, pk(1,3,0,0,1,32'h80,0,0,0,0,0));
    step("sc_c0_stolen", 1, 4'h0, 4'b0001, 4'b0001, 32'h80, Z, Z, Z, pk(1,0,0,0,0,32'h80,1,0,0,0,0));
    idle("sc_fail_c0", 4'b0001);
    idle("sc_fail_clear", 4'h0);

    // re and we together: write only
    step("rw_both", 1, 4'b0010, 4'b0010, 4'h0, Z, 32'h10, Z, Z, pk(1,1,0,0,1,32'h10,0,0,0,0,0));

    // LL/SC to I/O space: no reservation, SC always fails, strobe suppressed
    step("ll_io", 1, 4'b0100, 4'h0, 4'b0100, Z, Z, 32'hFFFF_0100, Z,
         pk(1,2,0,0,0,32'hFFFF_0100,0,0,0,0,0));
    step("sc_io", 1, 4'h0, 4'b0100, 4'b0100, Z, Z, 32'hFFFF_0100, Z,
         pk(1,2,0,0,0,32'hFFFF_0100,1,0,0,0,0));
    idle("sc_io_fail", 4'b0100);

    // reset mid-traffic clears pointer, reservations and a pending sc_fail
    step("ll_c0_pre", 1, 4'b0001, 4'h0, 4'b0001, 32'h200, Z, Z, Z, pk(1,0,0,1,0,32'h200,0,0,0,0,0));
    step("sc_c2_bad", 1, 4'h0, 4'b0100, 4'b0100, Z, Z, 32'h300, Z, pk(1,2,0,0,0,32'h300,1,0,0,0,0));
    step("rst_mid", 0, 4'hF, 4'h0, 4'h0, A0, A1, A2, A3, pk(1,0,4'b1110,1,0,A0,0,0,0,0,0));
    step("rst_mid2", 0, 4'hF, 4'h0, 4'h0, A0, A1, A2, A3, pk(1,0,4'b1110,1,0,A0,0,0,0,0,0));
    idle("rst_release", 4'h0);
    step("sc_after_rst", 1, 4'h0, 4'b0001, 4'b0001, 32'h200, Z, Z, Z, pk(1,0,0,0,0,32'h200,1,0,0,0,0));
    idle("sc_fail_after_rst", 4'b0001);

    // drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mbs_bus_arbiter_rr.md
Name: mbs_bus_arbiter_rr

Overview:
- Parametrised N-core shared-bus arbiter and address decoder for the MBSsoc interconnect; successor to the fixed two-core bus controller.
- Grants one core per cycle by round-robin and stalls every other requester.
- Decodes the granted address to RAM, APIC or UART strobes.
- Keeps a per-core load-linked/store-conditional reservation table so atomic sequences stay correct with any core count.

Parameters:
CORE_NUM, 4, number of CPU cores (2..8)
ADDR_WIDTH, 32, address width
RAM_LIMIT, 32'h0200_0000, addresses below this decode to RAM
APIC_CONF_ADDR, 32'hFFFF_0000, APIC configuration register
APIC_PC_BASE, 32'hFFFF_0010, per-core PC register at APIC_PC_BASE + 4*i
UART_DATA_ADDR, 32'hFFFF_0100, UART transmit data register

Ports:
clk  in  1  system clock
rst_n  in  1  reset
req_re  in  CORE_NUM  per-core read request
req_we  in  CORE_NUM  per-core write request
req_lock  in  CORE_NUM  access is LL (with re) or SC (with we)
req_addr  in  CORE_NUM*ADDR_WIDTH  core i address at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
cpu_pause  out  CORE_NUM  stall to requesting, non-granted cores
grant_valid  out  1  a core holds the bus this cycle
grant_sel  out  $clog2(CORE_NUM)  granted core index
ram_re  out  1  RAM read strobe
ram_we  out  1  RAM write strobe
ram_addr  out  ADDR_WIDTH  RAM address
ram_wr_invalid  out  1  failing SC; write suppressed
apic_conf  out  1  APIC config write strobe
apic_pc  out  CORE_NUM  APIC per-core PC write strobe
uart_we  out  1  UART data write strobe
sc_fail  out  CORE_NUM  registered one-cycle pulse: SC of core i failed

Behaviour:
- Reset is asynchronous and active-low on rst_n; all other logic is clocked on clk rising edge.
- Reset: rr_ptr=0, all reservations invalid, sc_fail=0.
- Combinational outputs during reset follow the inputs using that reset state.
- Request: core i requests when req_re[i] | req_we[i]. If both are set, the write wins and the read is ignored.
- Arbitration: combinational, zero latency. Grant goes to the first requester at or after rr_ptr, searching upward with wrap-around.
- grant_valid = any request. With no request: grant_sel=0, all strobes 0, ram_addr=0.
- cpu_pause[i] = request[i] & ~(granted i). A non-requesting core is never paused.
- rr_ptr updates to (grant_sel+1) mod CORE_NUM on each grant and holds when idle. Worst-case wait is CORE_NUM-1 cycles.
- Decode of the granted address (addr):
  - addr < RAM_LIMIT: ram_re/ram_we follow the request, ram_addr=addr.
  - Otherwise exact match drives a write-only strobe: APIC_CONF_ADDR -> apic_conf, APIC_PC_BASE+4*i -> apic_pc[i], UART_DATA_ADDR -> uart_we.
  - Reads of I/O addresses and unmapped addresses produce no strobe.
- Reservation table: resv_v[i] and resv_a[i] per core.
- LL (granted re & lock): set resv_v[g]=1, resv_a[g]=addr on the next edge.
- SC (granted we & lock):
  - Success when resv_v[g] & resv_a[g]==addr: the write proceeds.
  - Otherwise: ram_wr_invalid=1 in the same cycle, every write strobe is forced to 0, and sc_fail[g] pulses on the next cycle.
  - A successful SC clears resv_v[g].
- Any successful write, plain or SC, from core g to addr clears resv_v[k] for every k≠g with resv_a[k]==addr.
- Same-edge conflict: an LL by core g sets g's entry; clears from the other rule apply to other cores only.
- Reservations cover only addresses below RAM_LIMIT. An LL to I/O space does not set a reservation; an SC to I/O space always fails.

Decomposition:
- Shared package mbs_bus_pkg: address-map constants (RAM_LIMIT, APIC_*, UART_DATA_ADDR) and the ctrl-bus bit indices.
- One sub-module, mbs_rr_picker: request vector plus pointer in, one-hot grant plus index out. It is purely combinational and reusable by the DMA arbiter.

Test Plan:
- Reset: rst_n low mid-traffic, then release, no requests -> cpu_pause=0, sc_fail=0, grant_valid=0; the next LL+SC pair from core 0 fails because reservations were cleared.
- Round-robin: all 4 cores request a RAM read continuously -> grant_sel sequence 0,1,2,3,0. Each core is paused in exactly 3 of 4 cycles.
- Decode: core 2 alone writes 32'hFFFF_0018 -> apic_pc=4'b0100, ram_we=0. Core 1 reads 32'h0000_1000 -> ram_re=1, ram_addr=32'h1000.
- LL/SC success: core 1 LL 0x40, then SC 0x40 -> ram_we=1, ram_wr_invalid=0, sc_fail=0.
- LL/SC steal: core 0 LL 0x80; core 3 plain write 0x80; core 0 SC 0x80 -> ram_we=0, ram_wr_invalid=1, sc_fail[0] pulses 1 cycle later.
- Simultaneous request: core 1 asserts re and we together at 0x10 -> treated as a write only, ram_we=1, ram_re=0.
